// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the practice ALU.
//   - OP_* : selector codes for the 1-bit logic cell
//   - state_t : FSM states of the bit-serial sequencer
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cl.sv
// cl: 1-bit logic cell.
// Ports:
//   a_i, b_i : operand bits
//   s_i      : function select (AND / OR / XOR / NOT a)
//   y_o      : result bit (combinational)
module cl
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] s_i,
  output logic       y_o
);

  always_comb begin
    y_o = 1'b0;
    case (s_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOT:  y_o = ~a_i;
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer around a single 1-bit logic cell.
// Processes WIDTH-bit operands LSB first, one bit per clock, and assembles
// the result in a shift register.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   start  : request, sampled only in IDLE or DONE
//   a, b   : operands, latched on the accepting edge
//   op     : cell selector, latched with the operands
//   busy   : high while processing bits
//   done   : one-cycle completion pulse
//   result : assembled result
//   zero   : result == 0, captured on entry to DONE
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [1:0]       sop_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;

  logic             cl_y;
  logic [WIDTH-1:0] result_d;

  cl u_cl (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .s_i (sop_q),
    .y_o (cl_y)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  assign result_d = {cl_y, result_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sop_q    <= OP_AND;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            sop_q   <= op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            zero_q  <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            zero_q  <= (result_d == '0);
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         busy, done, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [1:0] mop);
    case (mop)
      2'b00:   return ma & mb;
      2'b01:   return ma | mb;
      2'b10:   return ma ^ mb;
      default: return ~ma;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Drive a request one negedge ahead of the accepting edge; returns after it.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top);
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Same, but assumes we are already at a negedge (used during DONE).
  task automatic accept_now(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top);
    a = ta; b = tb; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after the accepting edge. Counts edges until done, checks
  // latency, busy length, result and zero. poke_at >= 0 fires a stray start
  // with altered operands at that edge count.
  task automatic wait_done(input string name, input logic [W-1:0] exp_res,
                           input logic exp_zero, input int poke_at);
    int edges = 1;
    int busy_n = 0;
    while (!done && edges < 40) begin
      if (busy) busy_n++;
      if (poke_at >= 0 && edges == poke_at) begin
        start = 1'b1; a = ~a; op = op ^ 2'b11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(done), 32'd1);
    check({name, " latency"}, 32'(edges), 32'(W + 1));
    check({name, " busy_cycles"}, 32'(busy_n), 32'(W));
    check({name, " result"}, 32'(result), 32'(exp_res));
    check({name, " zero"}, 32'(zero), 32'(exp_zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    logic [W-1:0] ra, rb, rexp;
    logic [1:0]   rop;

    vecs[0] = '{8'hA5, 8'h0F, OP_AND, 8'h05, 1'b0};
    vecs[1] = '{8'hA5, 8'h0F, OP_OR,  8'hAF, 1'b0};
    vecs[2] = '{8'hA5, 8'h0F, OP_XOR, 8'hAA, 1'b0};
    vecs[3] = '{8'hA5, 8'h0F, OP_NOT, 8'h5A, 1'b0};
    vecs[4] = '{8'hA5, 8'hFF, OP_NOT, 8'h5A, 1'b0};
    vecs[5] = '{8'h3C, 8'h3C, OP_XOR, 8'h00, 1'b1};
    vecs[6] = '{8'h01, 8'h00, OP_OR,  8'h01, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset result", 32'(result), 0);
    check("reset zero", 32'(zero), 0);

    // Table of directed vectors, each followed by a single-cycle done check.
    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_zero, -1);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse_width", i), 32'(done), 0);
    end

    // Back-to-back: start during DONE, each op 9 edges after the previous done.
    accept(8'hF0, 8'h33, OP_AND);
    wait_done("b2b0", 8'h30, 1'b0, -1);
    accept_now(8'h0C, 8'hC0, OP_OR);
    wait_done("b2b1", 8'hCC, 1'b0, -1);
    accept_now(8'h55, 8'h55, OP_XOR);
    wait_done("b2b2", 8'h00, 1'b1, -1);

    // Stray start plus operand/op change mid-run must not disturb the result.
    accept(8'hC3, 8'h5A, OP_XOR);
    wait_done("ignored_start", 8'h99, 1'b0, 3);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored_start extra_done", 32'(dones), 0);

    // Reset mid-run at bit 4: state cleared, no done afterwards.
    accept(8'hFF, 8'hFF, OP_AND);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", 32'(busy), 0);
    check("midreset result", 32'(result), 0);
    check("midreset done", 32'(done), 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midreset no_activity", 32'(dones), 0);
    accept(8'h81, 8'h18, OP_OR);
    wait_done("after_reset", 8'h99, 1'b0, -1);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_vs_start busy", 32'(busy), 0);

    // Randomised operations against the word-level model.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom_range(0, 3));
      if (i % 5 == 2) rb = ra;
      rexp = model(ra, rb, rop);
      if (i > 0 && $urandom_range(0, 1) == 1) accept_now(ra, rb, rop);
      else accept(ra, rb, rop);
      wait_done($sformatf("rand%0d a=%0h b=%0h op=%0d", i, ra, rb, rop), rexp, rexp == '0, -1);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
